multi_channel_data_synchronizer: RTL and testbench
==================================================

// Module: multi_channel_data_synchronizer
// PURPOSE
//  Multi-channel successor to the single-channel data synchronizer. It sits in the destination clock domain.
//  It takes CHANNEL_COUNT independent asynchronous valid/data pairs and synchronizes each valid through a
//  STAGE_COUNT flop chain. Each detected event captures that channel's bus into a one-entry holding register.
//  Pending channels are merged round-robin onto a single registered valid/ready output stream.
//  Supports level mode (rising-edge event) and toggle mode (any-edge event), plus sticky per-channel overflow flags.
// PARAMETERS
//  STAGE_COUNT   2  synchronizer flops per channel valid (>=2)
//  BUS_WIDTH     8  data width per channel
//  CHANNEL_COUNT 4  number of source channels (>=1)
//  TOGGLE_MODE   0  0: event = rising edge of synced valid; 1: event = any edge of synced valid
//  (CH_W = CHANNEL_COUNT>1 ? $clog2(CHANNEL_COUNT) : 1, derived localparam)
// PORTS
//  clk                      in   1                       destination-domain clock
//  reset                    in   1                       synchronous, active-high reset
//  asynchronous_data_valid  in   CHANNEL_COUNT           per-channel async valid (level or toggle)
//  asynchronous_data        in   CHANNEL_COUNT*BUS_WIDTH channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//  synchronous_ready        in   1                       downstream accepts output this cycle
//  overflow_clear           in   1                       clears all overflow bits
//  synchronous_data_valid   out  1                       output word valid
//  synchronous_data         out  BUS_WIDTH               output word
//  synchronous_channel      out  CH_W                    source channel index of output word
//  channel_pending          out  CHANNEL_COUNT           holding register i occupied
//  overflow                 out  CHANNEL_COUNT           sticky: event lost on channel i
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - Clears all sync flops, edge registers, holding registers, pending bits, output regs and overflow.
//    - Clears the round-robin pointer to 0.
//  - Per channel:
//    - s_i is the last sync stage; q_i <= s_i every cycle.
//    - ev_i = TOGGLE_MODE ? (s_i ^ q_i) : (s_i & ~q_i).
//  - Capture on ev_i:
//    - If the channel is not pending, or is granted this same cycle, the hold register takes the data slice and pending is set next edge.
//    - If the channel is pending and not granted, the new data is dropped, the held data is kept and overflow[i] is set.
//  - Overflow bits are sticky. overflow_clear zeroes them, but a same-cycle set wins.
//  - Output register load:
//    - Loads when it is empty or when valid&ready this cycle.
//    - Source is the first pending channel at or after the pointer, wrapping at CHANNEL_COUNT.
//    - On grant: that channel's pending bit clears and the pointer moves to (granted+1) mod CHANNEL_COUNT.
//    - If nothing is pending, valid drops after the handshake.
//  - Output hold: while valid & ~ready, synchronous_data and synchronous_channel stay stable.
//  - Throughput: one word per cycle with ready held high, back-to-back across channels.
//  - Latency, idle block: async valid edge sampled at edge 1 -> synchronous_data_valid high after edge STAGE_COUNT+2.
//  - Source contract: asynchronous_data must be stable from before the valid edge until STAGE_COUNT+2 destination cycles after it.
//  - Toggle mode with a source valid high at reset release produces one event. Sources must reset with this block.
//  - Reset mid-operation discards pending and in-flight words. No output is produced for discarded words.
// TESTING
//  1. Level mode, ch0 valid 0->1 with data 8'hA5, ready=1:
//     -> valid=1, data=A5, channel=0 exactly STAGE_COUNT+2 cycles later, for 1 cycle only.
//  2. Toggle mode, ch2 toggles twice, 10 cycles apart, data 8'h11 then 8'h22:
//     -> two outputs on channel 2, 11 then 22; no overflow.
//  3. All 4 channels fire the same cycle, ready=1, pointer=0:
//     -> outputs on 4 consecutive cycles in channel order 0,1,2,3.
//  4. ready=0 with ch1 pending, then a second ch1 event:
//     -> overflow[1]=1 and the first data is retained.
//     -> overflow_clear pulse -> overflow[1]=0.
//  5. ready toggled randomly, 4 channels firing:
//     -> data and channel stable while stalled; none lost or duplicated.
//     -> output order matches round-robin.
//  6. Assert reset while 3 channels are pending:
//     -> next cycle all outputs are 0; no output after release until new events arrive.

Source files
------------

// File: rtl/multi_channel_data_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_data_synchronizer
// Purpose  : Destination-domain collector for CHANNEL_COUNT independent
//            asynchronous valid/data sources. Each channel's valid passes
//            through a STAGE_COUNT flop synchronizer. A detected event
//            captures that channel's data bus into a one-entry holding
//            register. Pending channels are merged round-robin onto one
//            registered valid/ready output stream. Events that arrive while
//            a channel's holding register is still occupied are dropped and
//            recorded in a sticky per-channel overflow flag.
//
// Ports    : clk                     destination-domain clock
//            reset                   synchronous, active-high reset
//            asynchronous_data_valid per-channel async valid (level/toggle)
//            asynchronous_data       channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//            synchronous_ready       downstream accepts the output word
//            overflow_clear          clears every overflow bit
//            synchronous_data_valid  output word valid
//            synchronous_data        output word
//            synchronous_channel     source channel of the output word
//            channel_pending         holding register i occupied
//            overflow                sticky: an event was lost on channel i
//
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_data_synchronizer #(
    parameter int STAGE_COUNT   = 2,
    parameter int BUS_WIDTH     = 8,
    parameter int CHANNEL_COUNT = 4,
    parameter int TOGGLE_MODE   = 0,
    localparam int CH_W         = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNEL_COUNT-1:0]         asynchronous_data_valid,
    input  logic [CHANNEL_COUNT*BUS_WIDTH-1:0] asynchronous_data,
    input  logic                             synchronous_ready,
    input  logic                             overflow_clear,
    output logic                             synchronous_data_valid,
    output logic [BUS_WIDTH-1:0]             synchronous_data,
    output logic [CH_W-1:0]                  synchronous_channel,
    output logic [CHANNEL_COUNT-1:0]         channel_pending,
    output logic [CHANNEL_COUNT-1:0]         overflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CH_W:0]   c_CHAN_COUNT_EXT = (CH_W+1)'(CHANNEL_COUNT);
    localparam logic [CH_W-1:0] c_LAST_CHAN      = CH_W'(CHANNEL_COUNT - 1);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    // Per-channel event detection
    logic [CHANNEL_COUNT-1:0]   w_event;
    logic [BUS_WIDTH-1:0]       w_chan_data [CHANNEL_COUNT];

    // Holding registers and status
    logic [BUS_WIDTH-1:0]       r_hold [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0]   r_pending;
    logic [CHANNEL_COUNT-1:0]   r_overflow;
    logic [CHANNEL_COUNT-1:0]   w_overflow_set;

    // Arbitration
    logic [CH_W-1:0]            r_ptr;
    logic [2*CHANNEL_COUNT-1:0] w_pend_dbl;
    logic [CHANNEL_COUNT-1:0]   w_pend_rot;
    logic                       w_sel_found;
    logic [CH_W:0]              w_sel_off;
    logic [CH_W:0]              w_sel_sum;
    logic [CH_W-1:0]            w_sel_idx;
    logic [CH_W-1:0]            w_next_ptr;
    logic                       w_load;
    logic [CHANNEL_COUNT-1:0]   w_grant;

    // Output stage
    logic                       r_out_valid;
    logic [BUS_WIDTH-1:0]       r_out_data;
    logic [CH_W-1:0]            r_out_channel;

    // ------------------------------------------------------------------------
    // Per-channel synchronizer and edge detector
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_chan
        logic [STAGE_COUNT-1:0] r_sync;
        logic                   r_sync_q;
        logic                   w_sync_out;

        // Stage 0 is the only flop that ever sees the asynchronous input;
        // the MSB is the first metastability-safe copy.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync   <= '0;
                r_sync_q <= 1'b0;
            end else begin
                r_sync   <= {r_sync[STAGE_COUNT-2:0], asynchronous_data_valid[gi]};
                r_sync_q <= r_sync[STAGE_COUNT-1];
            end
        end

        assign w_sync_out      = r_sync[STAGE_COUNT-1];
        assign w_chan_data[gi] = asynchronous_data[gi*BUS_WIDTH +: BUS_WIDTH];

        if (TOGGLE_MODE != 0) begin : g_toggle
            // Every transition of the source valid is one word.
            assign w_event[gi] = w_sync_out ^ r_sync_q;
        end else begin : g_level
            // Only the rising edge of the source valid is a word.
            assign w_event[gi] = w_sync_out & ~r_sync_q;
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------------
    // Duplicating the pending vector and slicing at the pointer gives a view
    // where bit k is channel (ptr + k) mod CHANNEL_COUNT, so the first set bit
    // is the offset of the winner from the pointer.
    assign w_pend_dbl = {r_pending, r_pending};
    assign w_pend_rot = w_pend_dbl[r_ptr +: CHANNEL_COUNT];

    always_comb begin
        w_sel_found = 1'b0;
        w_sel_off   = '0;
        // Descending scan: the lowest set offset is written last and wins.
        for (int k = CHANNEL_COUNT - 1; k >= 0; k--) begin
            if (w_pend_rot[k]) begin
                w_sel_found = 1'b1;
                w_sel_off   = (CH_W+1)'(k);
            end
        end
        w_sel_sum = {1'b0, r_ptr} + w_sel_off;
        if (w_sel_sum >= c_CHAN_COUNT_EXT) begin
            w_sel_sum = w_sel_sum - c_CHAN_COUNT_EXT;
        end
        w_sel_idx = w_sel_sum[CH_W-1:0];
    end

    assign w_next_ptr = (w_sel_idx == c_LAST_CHAN) ? '0 : (w_sel_idx + CH_W'(1));

    // The output register may be (re)loaded when it is empty or when its
    // current word is being accepted this cycle.
    assign w_load = ~r_out_valid | synchronous_ready;

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            w_grant[i] = w_load & w_sel_found & (w_sel_idx == CH_W'(i));
        end
    end

    // ------------------------------------------------------------------------
    // Holding registers and pending flags
    // ------------------------------------------------------------------------
    // A channel granted in the same cycle as a new event frees its slot on
    // this edge, so the new word can be captured without loss; the output
    // register takes the old held word at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                if (w_event[i] && (!r_pending[i] || w_grant[i])) begin
                    r_hold[i]    <= w_chan_data[i];
                    r_pending[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky overflow flags
    // ------------------------------------------------------------------------
    // A new event that finds its slot still occupied is dropped; the held
    // word is kept. A set in the same cycle as a clear survives the clear.
    assign w_overflow_set = w_event & r_pending & ~w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= (overflow_clear ? '0 : r_overflow) | w_overflow_set;
        end
    end

    // ------------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------------
    // Data and channel only change on a load, so they stay stable for the
    // whole time the output is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_channel <= '0;
            r_ptr         <= '0;
        end else if (w_load) begin
            if (w_sel_found) begin
                r_out_valid   <= 1'b1;
                r_out_data    <= r_hold[w_sel_idx];
                r_out_channel <= w_sel_idx;
                r_ptr         <= w_next_ptr;
            end else begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Port assignments
    // ------------------------------------------------------------------------
    assign synchronous_data_valid = r_out_valid;
    assign synchronous_data       = r_out_data;
    assign synchronous_channel    = r_out_channel;
    assign channel_pending        = r_pending;
    assign overflow               = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_data_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_data_synchronizer
// Purpose  : Self-checking bench for multi_channel_data_synchronizer with one
//            level-mode and one toggle-mode instance (STAGE_COUNT=2,
//            BUS_WIDTH=8, CHANNEL_COUNT=4). Expected values are hand-computed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_data_synchronizer;

    localparam int STAGES = 2;
    localparam int BW     = 8;
    localparam int NCH    = 4;
    localparam int NVEC   = 18;

    logic        clk;
    logic        reset;

    // Level-mode instance
    logic [3:0]  l_av;
    logic [31:0] l_ad;
    logic        l_rdy;
    logic        l_clr;
    logic        l_v;
    logic [7:0]  l_d;
    logic [1:0]  l_c;
    logic [3:0]  l_p;
    logic [3:0]  l_o;

    // Toggle-mode instance
    logic [3:0]  t_av;
    logic [31:0] t_ad;
    logic        t_rdy;
    logic        t_clr;
    logic        t_v;
    logic [7:0]  t_d;
    logic [1:0]  t_c;
    logic [3:0]  t_p;
    logic [3:0]  t_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  av;
        logic [31:0] ad;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  ec;
        logic [3:0]  ep;
    } vec_t;

    vec_t vecs [NVEC];

    multi_channel_data_synchronizer #(
        .STAGE_COUNT(STAGES), .BUS_WIDTH(BW), .CHANNEL_COUNT(NCH), .TOGGLE_MODE(0)
    ) u_level (
        .clk(clk), .reset(reset),
        .asynchronous_data_valid(l_av), .asynchronous_data(l_ad),
        .synchronous_ready(l_rdy), .overflow_clear(l_clr),
        .synchronous_data_valid(l_v), .synchronous_data(l_d),
        .synchronous_channel(l_c), .channel_pending(l_p), .overflow(l_o)
    );

    multi_channel_data_synchronizer #(
        .STAGE_COUNT(STAGES), .BUS_WIDTH(BW), .CHANNEL_COUNT(NCH), .TOGGLE_MODE(1)
    ) u_toggle (
        .clk(clk), .reset(reset),
        .asynchronous_data_valid(t_av), .asynchronous_data(t_ad),
        .synchronous_ready(t_rdy), .overflow_clear(t_clr),
        .synchronous_data_valid(t_v), .synchronous_data(t_d),
        .synchronous_channel(t_c), .channel_pending(t_p), .overflow(t_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One level-mode event: valid high long enough to be captured, then low
    // long enough for the synchronizer to settle back to zero.
    task automatic pulse_level(input int ch, input logic [7:0] d);
        l_ad[ch*8 +: 8] = d;
        l_av[ch]        = 1'b1;
        repeat (4) tick();
        l_av[ch]        = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] exp_d [4];
        logic [1:0] exp_c [4];
        logic       pre_v, pre_r;
        logic [7:0] pre_d;
        logic [1:0] pre_c;
        int         got;
        int         seen;

        // Vector table: each row is applied, one clock edge taken, then the
        // outputs after that edge are compared.
        // Rows 0-9: all four channels fire together, pointer at 0.
        vecs[0]  = '{4'b1111, 32'h44332211, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[1]  = '{4'b1111, 32'h44332211, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[2]  = '{4'b1111, 32'h44332211, 1'b1, 1'b0, 8'h00, 2'd0, 4'b1111};
        vecs[3]  = '{4'b1111, 32'h44332211, 1'b1, 1'b1, 8'h11, 2'd0, 4'b1110};
        vecs[4]  = '{4'b1111, 32'h44332211, 1'b1, 1'b1, 8'h22, 2'd1, 4'b1100};
        vecs[5]  = '{4'b1111, 32'h44332211, 1'b1, 1'b1, 8'h33, 2'd2, 4'b1000};
        vecs[6]  = '{4'b1111, 32'h44332211, 1'b1, 1'b1, 8'h44, 2'd3, 4'b0000};
        vecs[7]  = '{4'b1111, 32'h44332211, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[8]  = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[9]  = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
        // Rows 10-17: single ch0 rising edge with A5, STAGE_COUNT+2 latency,
        // one-cycle output; the falling edge makes no word.
        vecs[10] = '{4'b0001, 32'h000000A5, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[11] = '{4'b0001, 32'h000000A5, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[12] = '{4'b0001, 32'h000000A5, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0001};
        vecs[13] = '{4'b0001, 32'h000000A5, 1'b1, 1'b1, 8'hA5, 2'd0, 4'b0000};
        vecs[14] = '{4'b0001, 32'h000000A5, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[15] = '{4'b0000, 32'h000000A5, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[16] = '{4'b0000, 32'h000000A5, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[17] = '{4'b0000, 32'h000000A5, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};

        // ---------------- reset ----------------
        reset = 1'b1;
        l_av = '0; l_ad = '0; l_rdy = 1'b1; l_clr = 1'b0;
        t_av = '0; t_ad = '0; t_rdy = 1'b1; t_clr = 1'b0;
        repeat (3) tick();
        check("reset_l_valid",    l_v, 0);
        check("reset_l_data",     l_d, 0);
        check("reset_l_channel",  l_c, 0);
        check("reset_l_pending",  l_p, 0);
        check("reset_l_overflow", l_o, 0);
        check("reset_t_valid",    t_v, 0);
        check("reset_t_pending",  t_p, 0);
        reset = 1'b0;

        // ---------------- table-driven vectors (level mode) ----------------
        for (int r = 0; r < NVEC; r++) begin
            l_av  = vecs[r].av;
            l_ad  = vecs[r].ad;
            l_rdy = vecs[r].rdy;
            tick();
            check($sformatf("vec%0d_valid", r), l_v, vecs[r].ev);
            if (vecs[r].ev) begin
                check($sformatf("vec%0d_data", r),    l_d, vecs[r].ed);
                check($sformatf("vec%0d_channel", r), l_c, vecs[r].ec);
            end
            check($sformatf("vec%0d_pending", r),  l_p, vecs[r].ep);
            check($sformatf("vec%0d_overflow", r), l_o, 0);
        end

        // ---------------- toggle mode: ch2 toggles twice ----------------
        t_ad[23:16] = 8'h11;
        t_av[2]     = 1'b1;
        repeat (3) tick();
        check("tog1_early", t_v, 0);
        tick();
        check("tog1_valid",   t_v, 1);
        check("tog1_data",    t_d, 8'h11);
        check("tog1_channel", t_c, 2);
        tick();
        check("tog1_single", t_v, 0);
        repeat (5) tick();
        t_ad[23:16] = 8'h22;
        t_av[2]     = 1'b0;
        repeat (3) tick();
        check("tog2_early", t_v, 0);
        tick();
        check("tog2_valid",   t_v, 1);
        check("tog2_data",    t_d, 8'h22);
        check("tog2_channel", t_c, 2);
        tick();
        check("tog2_single",   t_v, 0);
        check("tog_overflow",  t_o, 0);
        check("tog_pending",   t_p, 0);

        // ---------------- overflow while stalled on ch1 ----------------
        l_rdy = 1'b0;
        pulse_level(1, 8'h5A);
        check("ovf_first_valid",   l_v, 1);
        check("ovf_first_data",    l_d, 8'h5A);
        check("ovf_first_channel", l_c, 1);
        check("ovf_first_pending", l_p, 4'b0000);
        pulse_level(1, 8'h6B);
        check("ovf_second_pending", l_p, 4'b0010);
        check("ovf_second_hold",    l_d, 8'h5A);
        check("ovf_second_noovf",   l_o, 4'b0000);
        // Third event: the overflow set lands on the same edge as a clear.
        l_ad[15:8] = 8'h7C;
        l_av[1]    = 1'b1;
        tick();
        tick();
        l_clr = 1'b1;
        tick();
        l_clr = 1'b0;
        check("ovf_set_beats_clear", l_o, 4'b0010);
        tick();
        l_av[1] = 1'b0;
        repeat (3) tick();
        check("ovf_stall_valid",   l_v, 1);
        check("ovf_stall_data",    l_d, 8'h5A);
        check("ovf_stall_channel", l_c, 1);
        check("ovf_sticky",        l_o, 4'b0010);
        l_rdy = 1'b1;
        tick();
        check("ovf_retained_valid", l_v, 1);
        check("ovf_retained_data",  l_d, 8'h6B);
        check("ovf_retained_chan",  l_c, 1);
        check("ovf_drained",        l_p, 4'b0000);
        tick();
        check("ovf_no_third_word", l_v, 0);
        l_clr = 1'b1;
        tick();
        l_clr = 1'b0;
        check("ovf_cleared", l_o, 4'b0000);

        // ---------------- random ready, four channels, pointer at 2 ----------------
        exp_c = '{2'd2, 2'd3, 2'd0, 2'd1};
        exp_d = '{8'hC2, 8'hC3, 8'hC0, 8'hC1};
        got   = 0;
        l_ad  = 32'hC3C2C1C0;
        l_av  = 4'b1111;
        for (int cyc = 0; cyc < 120; cyc++) begin
            l_rdy = ((cyc % 3) == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            pre_v = l_v;
            pre_r = l_rdy;
            pre_d = l_d;
            pre_c = l_c;
            tick();
            if (pre_v && pre_r) begin
                if (got < 4) begin
                    check($sformatf("rr_word%0d_data", got),    pre_d, exp_d[got]);
                    check($sformatf("rr_word%0d_channel", got), pre_c, exp_c[got]);
                end
                got++;
            end else if (pre_v && !pre_r) begin
                check("rr_stall_hold", {l_v, l_c, l_d}, {1'b1, pre_c, pre_d});
            end
        end
        check("rr_word_count", got, 4);
        l_av  = 4'b0000;
        l_rdy = 1'b1;
        repeat (4) tick();
        check("rr_pending_empty", l_p, 4'b0000);
        check("rr_no_overflow",   l_o, 4'b0000);
        check("rr_idle",          l_v, 0);

        // ---------------- reset with three channels pending ----------------
        l_rdy = 1'b0;
        l_ad  = 32'hD3D2D1D0;
        l_av  = 4'b1111;
        repeat (5) tick();
        check("rst_pre_pending", l_p, 4'b1011);
        check("rst_pre_channel", l_c, 2);
        check("rst_pre_data",    l_d, 8'hD2);
        reset = 1'b1;
        l_av  = 4'b0000;
        tick();
        check("rst_valid",    l_v, 0);
        check("rst_data",     l_d, 0);
        check("rst_channel",  l_c, 0);
        check("rst_pending",  l_p, 0);
        check("rst_overflow", l_o, 0);
        reset = 1'b0;
        l_rdy = 1'b1;
        seen  = 0;
        repeat (10) begin
            tick();
            if (l_v) seen++;
        end
        check("rst_no_output", seen, 0);
        check("rst_still_empty", l_p, 0);
        l_ad[31:24] = 8'h3D;
        l_av[3]     = 1'b1;
        repeat (3) tick();
        check("rst_new_early", l_v, 0);
        tick();
        check("rst_new_valid",   l_v, 1);
        check("rst_new_data",    l_d, 8'h3D);
        check("rst_new_channel", l_c, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
